// File: rtl/pll_pkg.sv
// Shared types and frame-position constants for the PLL loop sequencer.
package pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_EVAL,
    ST_HOLD
  } pll_state_e;

  localparam logic [4:0] FRAME_LAST = 5'd31;
  localparam logic [4:0] EVAL_POS   = 5'd28;
  localparam logic [4:0] UPDATE_POS = 5'd30;

endpackage

// File: rtl/pll_edge_sync.sv
// Two-flop synchronizer for the feedback clock plus a one-cycle rising-edge pulse.
module pll_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pll_loop_sequencer.sv
// Frame sequencer: 32-cycle frames, feedback edge measurement, Slow/Fast request
// and consecutive-frame lock tracking.
module pll_loop_sequencer
  import pll_pkg::*;
#(
  parameter int COUNT_W     = 8,
  parameter int MEAS_LEN    = 28,
  parameter int DEADBAND    = 0,
  parameter int LOCK_FRAMES = 4
) (
  input  logic               REF_Clk,
  input  logic               Reset,
  input  logic               Enable,
  input  logic               Fb_In,
  input  logic [COUNT_W-1:0] Target_Count,
  output logic [7:0]         Time_Frame,
  output logic               Slow,
  output logic               Fast,
  output logic               Locked,
  output logic               Frame_Done,
  output logic [COUNT_W-1:0] Edge_Count
);

  localparam logic [4:0]                MEAS_LAST = 5'(MEAS_LEN - 1);
  localparam logic [COUNT_W-1:0]        CNT_MAX   = '1;
  localparam logic signed [COUNT_W:0]   DB        = (COUNT_W+1)'(DEADBAND);
  localparam logic [3:0]                LOCK_TGT  = 4'(LOCK_FRAMES);

  pll_state_e state_q, state_d;
  logic [4:0]         tf_q, tf_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] tgt_q, tgt_d;
  logic [COUNT_W-1:0] edge_q, edge_d;
  logic               slow_q, slow_d;
  logic               fast_q, fast_d;
  logic               locked_q, locked_d;
  logic [3:0]         lock_cnt_q, lock_cnt_d;

  logic                   fb_rise;
  logic                   frame_end;
  logic                   start_frame;
  logic                   eval_now;
  logic                   in_band;
  logic signed [COUNT_W:0] diff;

  pll_edge_sync u_edge_sync (
    .clk_i  (REF_Clk),
    .rst_ni (Reset),
    .d_i    (Fb_In),
    .rise_o (fb_rise)
  );

  assign frame_end   = (state_q == ST_HOLD) && (tf_q == FRAME_LAST);
  assign start_frame = Enable && ((state_q == ST_IDLE) || frame_end);
  assign eval_now    = (state_q == ST_EVAL) && (tf_q == EVAL_POS);
  assign diff        = $signed({1'b0, cnt_q}) - $signed({1'b0, tgt_q});
  assign in_band     = (diff >= -DB) && (diff <= DB);

  always_ff @(posedge REF_Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!Enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_MEASURE;
        ST_MEASURE: if (tf_q == MEAS_LAST) state_d = ST_EVAL;
        ST_EVAL:    if (tf_q == EVAL_POS) state_d = ST_HOLD;
        ST_HOLD:    if (tf_q == FRAME_LAST) state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Frame_Done = frame_end;
  end

  // Datapath next-state; Enable low discards the frame but keeps Edge_Count.
  always_comb begin
    tf_d       = tf_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    edge_d     = edge_q;
    slow_d     = slow_q;
    fast_d     = fast_q;
    locked_d   = locked_q;
    lock_cnt_d = lock_cnt_q;
    if (!Enable) begin
      tf_d       = '0;
      slow_d     = 1'b0;
      fast_d     = 1'b0;
      locked_d   = 1'b0;
      lock_cnt_d = '0;
    end else begin
      tf_d = (state_q == ST_IDLE) ? 5'd0 : tf_q + 5'd1;
      if (start_frame) begin
        cnt_d  = '0;
        tgt_d  = Target_Count;
        slow_d = 1'b0;
        fast_d = 1'b0;
      end
      if ((state_q == ST_MEASURE) && fb_rise && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (eval_now) begin
        edge_d = cnt_q;
        slow_d = (diff < -DB);
        fast_d = (diff > DB);
        if (in_band) begin
          lock_cnt_d = (lock_cnt_q == LOCK_TGT) ? lock_cnt_q : lock_cnt_q + 4'd1;
          locked_d   = (lock_cnt_d == LOCK_TGT);
        end else begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge REF_Clk or negedge Reset) begin
    if (!Reset) begin
      tf_q       <= '0;
      cnt_q      <= '0;
      tgt_q      <= '0;
      edge_q     <= '0;
      slow_q     <= 1'b0;
      fast_q     <= 1'b0;
      locked_q   <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      tf_q       <= tf_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      edge_q     <= edge_d;
      slow_q     <= slow_d;
      fast_q     <= fast_d;
      locked_q   <= locked_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign Time_Frame = {3'b000, tf_q};
  assign Slow       = slow_q;
  assign Fast       = fast_q;
  assign Locked     = locked_q;
  assign Edge_Count = edge_q;

endmodule
